// File: rtl/pong_pkg.sv
// Shared types and default constants for the Ping-Pong ball datapath.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } state_e;

  localparam int POS_W_DEF   = 8;
  localparam int POS_MAX_DEF = 255;
  localparam int DIV_DEF     = 4;

endpackage

// File: rtl/ball_track_step_prescaler.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the last count as a step.
module step_prescaler
  import pong_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // Count is pinned at zero whenever disabled so a new rally always starts a full period.
  always_comb begin
    step    = en && (count_q == LAST);
    count_d = '0;
    if (clr) begin
      count_d = '0;
    end else if (step) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ball_track.sv
// Ball position engine: serve, step, bounce on paddle hits, score pulse on misses.
module ball_track
  import pong_pkg::*;
#(
  parameter int POS_W   = POS_W_DEF,
  parameter int POS_MAX = POS_MAX_DEF,
  parameter int DIV     = DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serve_l,
  input  logic             serve_r,
  input  logic             hit_l,
  input  logic             hit_r,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             busy,
  output logic             score_l,
  output logic             score_r
);

  localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_MID = POS_W'(POS_MAX / 2);
  localparam logic [POS_W-1:0] P_ONE = POS_W'(1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             score_l_q, score_l_d;
  logic             score_r_q, score_r_d;
  logic             step;
  logic             serve_go;
  logic             run;

  assign serve_go = (state_q == IDLE) && (serve_l || serve_r);
  assign run      = (state_q != IDLE);

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (serve_go),
    .en    (run),
    .step  (step)
  );

  // Next-state logic; paddle inputs only matter on the step cycle at an end position.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (serve_l) begin
          pos_d   = '0;
          dir_d   = 1'b1;
          state_d = UP;
        end else if (serve_r) begin
          pos_d   = P_MAX;
          dir_d   = 1'b0;
          state_d = DN;
        end else begin
          state_d = IDLE;
        end
      end
      UP: begin
        if (!step) begin
          state_d = UP;
        end else if (pos_q < P_MAX) begin
          pos_d = pos_q + P_ONE;
        end else if (hit_r) begin
          pos_d   = P_MAX - P_ONE;
          dir_d   = 1'b0;
          state_d = DN;
        end else begin
          score_l_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DN: begin
        if (!step) begin
          state_d = DN;
        end else if (pos_q > '0) begin
          pos_d = pos_q - P_ONE;
        end else if (hit_l) begin
          pos_d   = P_ONE;
          dir_d   = 1'b1;
          state_d = UP;
        end else begin
          score_r_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= P_MID;
      dir_q     <= 1'b1;
      busy_q    <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign pos     = pos_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_ball_track.sv
// Self-checking bench for ball_track: cycle model feeds a queue of expected outputs.
module tb_ball_track;

  localparam int PW   = 4;
  localparam int PMAX = 7;
  localparam int PDIV = 2;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic          dir;
    logic          busy;
    logic          sl;
    logic          sr;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serve_l = 1'b0, serve_r = 1'b0, hit_l = 1'b0, hit_r = 1'b0;
  logic [PW-1:0] pos;
  logic          dir, busy, score_l, score_r;

  logic          s1_serve_l = 1'b0;
  logic [PW-1:0] pos1;
  logic          dir1, busy1, score_l1, score_r1;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  int   d1_q[$];

  int   m_st, m_pos, m_dir, m_cnt;
  logic m_sl, m_sr;

  always #5 clk = ~clk;

  ball_track #(.POS_W(PW), .POS_MAX(PMAX), .DIV(PDIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .serve_l(serve_l), .serve_r(serve_r),
    .hit_l(hit_l), .hit_r(hit_r), .pos(pos), .dir(dir), .busy(busy),
    .score_l(score_l), .score_r(score_r)
  );

  ball_track #(.POS_W(PW), .POS_MAX(PMAX), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .serve_l(s1_serve_l), .serve_r(1'b0),
    .hit_l(1'b0), .hit_r(1'b0), .pos(pos1), .dir(dir1), .busy(busy1),
    .score_l(score_l1), .score_r(score_r1)
  );

  function automatic obs_t cur();
    return obs_t'({pos, dir, busy, score_l, score_r});
  endfunction

  task automatic model_reset();
    m_st = 0; m_pos = PMAX / 2; m_dir = 1; m_cnt = 0; m_sl = 1'b0; m_sr = 1'b0;
  endtask

  // Drive one clock of inputs, advance the model, queue its prediction, then step the clock.
  task automatic cycle(input logic sl, input logic sr, input logic hl, input logic hr);
    bit   stp;
    int   nst, npos, ndir, ncnt;
    obs_t e;
    serve_l = sl; serve_r = sr; hit_l = hl; hit_r = hr;
    stp  = (m_st != 0) && (m_cnt == PDIV - 1);
    nst  = m_st; npos = m_pos; ndir = m_dir; ncnt = 0;
    m_sl = 1'b0; m_sr = 1'b0;
    case (m_st)
      0: begin
        if (sl) begin npos = 0; ndir = 1; nst = 1; end
        else if (sr) begin npos = PMAX; ndir = 0; nst = 2; end
      end
      1: begin
        ncnt = stp ? 0 : m_cnt + 1;
        if (stp) begin
          if (m_pos < PMAX) npos = m_pos + 1;
          else if (hr) begin ndir = 0; npos = PMAX - 1; nst = 2; end
          else begin m_sl = 1'b1; nst = 0; end
        end
      end
      default: begin
        ncnt = stp ? 0 : m_cnt + 1;
        if (stp) begin
          if (m_pos > 0) npos = m_pos - 1;
          else if (hl) begin ndir = 1; npos = 1; nst = 1; end
          else begin m_sr = 1'b1; nst = 0; end
        end
      end
    endcase
    m_st = nst; m_pos = npos; m_dir = ndir; m_cnt = ncnt;
    e.pos = PW'(npos); e.dir = (ndir != 0); e.busy = (nst != 0); e.sl = m_sl; e.sr = m_sr;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    serve_l = 1'b0; serve_r = 1'b0; hit_l = 1'b0; hit_r = 1'b0; s1_serve_l = 1'b0;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    d1_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    checks++;
    if (cur() !== obs_t'({4'd3, 1'b1, 1'b0, 1'b0, 1'b0})) begin
      errors++; $display("FAIL reset_state got %h exp %h", cur(), obs_t'({4'd3, 1'b1, 1'b0, 1'b0, 1'b0}));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      o = exp_q.pop_front();
      checks++;
      if (cur() !== o) begin errors++; $display("FAIL idle_hold cyc %0d got %h exp %h", i, cur(), o); end
    end
  endtask

  task automatic test_serve_l_bounce();
    obs_t o;
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      o = exp_q.pop_front();
      checks++;
      if (cur() !== o) begin errors++; $display("FAIL serve_l_rally cyc %0d got %h exp %h", i, cur(), o); end
      if (m_st == 2) break;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (pos !== 4'd6 || dir !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL right_bounce got pos=%0d dir=%b busy=%b exp pos=6 dir=0 busy=1", pos, dir, busy);
    end
  endtask

  task automatic test_miss_right();
    obs_t o;
    int   sl_seen = 0;
    bool_loop: begin
      do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
        o = exp_q.pop_front();
        checks++;
        if (cur() !== o) begin errors++; $display("FAIL miss_right cyc %0d got %h exp %h", i, cur(), o); end
        if (score_l === 1'b1) sl_seen++;
        if (m_st == 0) break;
        // serve_r on the final step cycle must be ignored: the rally is still running
        cycle(1'b0, (m_pos == PMAX && m_cnt == PDIV - 1), 1'b0, 1'b0);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    o = exp_q.pop_front();
    checks++;
    if (cur() !== o) begin errors++; $display("FAIL miss_right_after got %h exp %h", cur(), o); end
    checks++;
    if (sl_seen != 1 || pos !== 4'd7 || busy !== 1'b0 || score_l !== 1'b0) begin
      errors++; $display("FAIL score_l_pulse got pulses=%0d pos=%0d busy=%b exp pulses=1 pos=7 busy=0", sl_seen, pos, busy);
    end
  endtask

  task automatic test_left_hit_on_step();
    obs_t o;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      o = exp_q.pop_front();
      checks++;
      if (cur() !== o) begin errors++; $display("FAIL left_hit cyc %0d got %h exp %h", i, cur(), o); end
      if (m_st == 1) break;
      cycle(1'b0, 1'b0, (m_pos == 0 && m_cnt == PDIV - 1), 1'b0);
    end
    checks++;
    if (pos !== 4'd1 || dir !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL left_bounce got pos=%0d dir=%b exp pos=1 dir=1", pos, dir);
    end
  endtask

  task automatic test_left_early_swing();
    obs_t o;
    int   sr_seen = 0;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      o = exp_q.pop_front();
      checks++;
      if (cur() !== o) begin errors++; $display("FAIL early_swing cyc %0d got %h exp %h", i, cur(), o); end
      if (score_r === 1'b1) sr_seen++;
      if (m_st == 0) break;
      cycle(1'b0, 1'b0, (m_pos == 0 && m_cnt != PDIV - 1), 1'b0);
    end
    checks++;
    if (sr_seen != 1 || pos !== 4'd0 || dir !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL score_r_pulse got pulses=%0d pos=%0d dir=%b exp pulses=1 pos=0 dir=0", sr_seen, pos, dir);
    end
  endtask

  task automatic test_both_serve();
    obs_t o;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    o = exp_q.pop_front();
    checks++;
    if (cur() !== o) begin errors++; $display("FAIL both_serve got %h exp %h", cur(), o); end
    checks++;
    if (pos !== 4'd0 || dir !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL both_serve_left got pos=%0d dir=%b exp pos=0 dir=1", pos, dir);
    end
  endtask

  task automatic test_reset_mid_rally();
    obs_t o;
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      o = exp_q.pop_front();
      checks++;
      if (cur() !== o) begin errors++; $display("FAIL pre_reset cyc %0d got %h exp %h", i, cur(), o); end
      if (m_st == 1 && m_pos == 5) break;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cur() !== obs_t'({4'd3, 1'b1, 1'b0, 1'b0, 1'b0})) begin
      errors++; $display("FAIL async_reset got %h exp %h", cur(), obs_t'({4'd3, 1'b1, 1'b0, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    checks++;
    if (score_l !== 1'b0 || score_r !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_score got sl=%b sr=%b busy=%b exp 0 0 0", score_l, score_r, busy);
    end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_div1();
    int e;
    do_reset();
    s1_serve_l = 1'b1;
    @(posedge clk); #1;
    s1_serve_l = 1'b0;
    checks++;
    if (pos1 !== 4'd0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL div1_serve got pos=%0d busy=%b exp pos=0 busy=1", pos1, busy1);
    end
    for (int i = 1; i <= PMAX; i++) begin
      d1_q.push_back(i);
      @(posedge clk); #1;
      e = d1_q.pop_front();
      checks++;
      if (pos1 !== PW'(e)) begin errors++; $display("FAIL div1_step got pos=%0d exp %0d", pos1, e); end
    end
    @(posedge clk); #1;
    checks++;
    if (score_l1 !== 1'b1 || busy1 !== 1'b0 || pos1 !== 4'd7) begin
      errors++; $display("FAIL div1_miss got sl=%b busy=%b pos=%0d exp 1 0 7", score_l1, busy1, pos1);
    end
  endtask

  initial begin
    test_reset();
    test_serve_l_bounce();
    test_miss_right();
    test_left_hit_on_step();
    test_left_early_swing();
    test_both_serve();
    test_reset_mid_rally();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
